regfile_sequencer: RTL and testbench

- Single-issue micro-sequencer that drives the 8-entry x 8-bit register file (asel/bsel/csel/cload/cin) through a fixed READ-EXEC-WRITE schedule.
- Accepts one 16-bit instruction at a time over a valid/ready handshake and computes a small ALU result.
- Writes the result back to the register file and reports completion with flags.
- Sits between the instruction source (testbench or fetch unit) and the register file; it is the only agent driving the register file write and select ports.

---
 rtl/regfile_sequencer.sv | 145 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: READ-EXEC-WRITE micro-sequencer driving an 8x8 register file
module regfile_sequencer #(
  parameter int DW   = 8,
  parameter int SW   = 4,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [15:0]   instr,
  output logic          instr_ready,
  output logic [SW-1:0] asel,
  output logic [SW-1:0] bsel,
  input  logic [DW-1:0] aout,
  input  logic [DW-1:0] bout,
  output logic [SW-1:0] csel,
  output logic          cload,
  output logic [DW-1:0] cin,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          carry,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  state_t state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [DW:0] cr_q, cr_d, alu;
  logic [SW-1:0] asel_q, asel_d, bsel_q, bsel_d, csel_q, csel_d;
  logic wr_q, wr_d, err_q, err_d, zero_q, zero_d, carry_q, carry_d;
  logic [3:0] op;
  logic [SW-1:0] rd, rs1, rs2;
  logic writing, use1, use2, bad;
  assign op  = instr_q[15:12];
  assign rd  = instr_q[8 +: SW];
  assign rs1 = instr_q[4 +: SW];
  assign rs2 = instr_q[0 +: SW];
  assign writing = op >= 4'd1 && op <= 4'd9;
  assign use1    = op >= 4'd2 && op <= 4'd9;
  assign use2    = op >= 4'd3 && op <= 4'd7;
  assign bad = op >= 4'd10 || (writing && (32'(rd) >= NREG || (use1 && 32'(rs1) >= NREG) ||
               (use2 && 32'(rs2) >= NREG)));
  assign instr_ready = state_q == IDLE && rst;
  assign done  = state_q == WRITE;
  assign cload = done && wr_q;
  assign err   = done && err_q;
  assign cin   = cload ? cr_q[DW-1:0] : '0;
  assign asel  = asel_q;
  assign bsel  = bsel_q;
  assign csel  = csel_q;
  assign result = result_q;
  assign zero  = zero_q;
  assign carry = carry_q;
  // ALU: produce {carry, result} from the latched operands
  always_comb begin
    alu = '0;
    case (op)
      4'd1: alu = {1'b0, DW'(instr_q[7:0])};
      4'd2: alu = {1'b0, a_q};
      4'd3: alu = {1'b0, a_q} + {1'b0, b_q};
      4'd4: alu = {1'b0, a_q} - {1'b0, b_q};
      4'd5: alu = {1'b0, a_q & b_q};
      4'd6: alu = {1'b0, a_q | b_q};
      4'd7: alu = {1'b0, a_q ^ b_q};
      4'd8: alu = {a_q, 1'b0};
      4'd9: alu = {a_q[0], 1'b0, a_q[DW-1:1]};
      default: alu = '0;
    endcase
  end
  // Next-state: sequence through READ/EXEC/WRITE and stage all registered outputs
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    a_d = a_q;
    b_d = b_q;
    cr_d = cr_q;
    asel_d = asel_q;
    bsel_d = bsel_q;
    csel_d = csel_q;
    wr_d = wr_q;
    err_d = err_q;
    result_d = result_q;
    zero_d = zero_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: if (instr_valid) begin
        instr_d = instr;
        asel_d = instr[4 +: SW];
        bsel_d = instr[0 +: SW];
        state_d = READ;
      end
      READ: begin
        a_d = aout;
        b_d = bout;
        state_d = EXEC;
      end
      EXEC: begin
        cr_d = alu;
        wr_d = writing && !bad;
        err_d = bad;
        if (writing && !bad) begin
          csel_d = rd;
          result_d = alu[DW-1:0];
          zero_d = alu[DW-1:0] == '0;
          carry_d = alu[DW];
        end
        state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers, cleared by asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cr_q <= '0;
      asel_q <= '0;
      bsel_q <= '0;
      csel_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      result_q <= '0;
      zero_q <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q <= a_d;
      b_q <= b_d;
      cr_q <= cr_d;
      asel_q <= asel_d;
      bsel_q <= bsel_d;
      csel_q <= csel_d;
      wr_q <= wr_d;
      err_q <= err_d;
      result_q <= result_d;
      zero_q <= zero_d;
      carry_q <= carry_d;
    end
  end
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: random and directed checks against an arithmetic reference model
module tb_regfile_sequencer;
  logic clk = 0, rst = 0, instr_valid = 0;
  logic [15:0] instr = '0;
  logic instr_ready, cload, done, zero, carry, err;
  logic [3:0] asel, bsel, csel;
  logic [7:0] aout, bout, cin, result;
  logic [7:0] rf [8];
  logic [7:0] ref_rf [8];
  logic [7:0] ref_res;
  logic ref_z, ref_c;
  int n_chk = 0, n_fail = 0;

  regfile_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .asel(asel), .bsel(bsel), .aout(aout), .bout(bout), .csel(csel), .cload(cload), .cin(cin),
    .done(done), .result(result), .zero(zero), .carry(carry), .err(err)
  );

  always #5 clk = ~clk;

  // Register file the sequencer drives: async read, write on rising edge, reset clears all
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) for (int i = 0; i < 8; i++) rf[i] <= '0;
    else if (cload && csel < 4'd8) rf[csel[2:0]] <= cin;
  end
  assign aout = asel < 4'd8 ? rf[asel[2:0]] : 8'h00;
  assign bout = bsel < 4'd8 ? rf[bsel[2:0]] : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    for (int r = 0; r < 8; r++) ref_rf[r] = '0;
    ref_res = '0; ref_z = 0; ref_c = 0;
  endtask

  // Behavioural model: what one instruction should do given the current register contents
  task automatic model(input logic [15:0] i, output bit wr, output logic [7:0] v, output bit c, output bit e);
    int op = int'(i[15:12]), rd = int'(i[11:8]), s1 = int'(i[7:4]), s2 = int'(i[3:0]);
    int a = s1 < 8 ? int'(ref_rf[s1]) : 0;
    int b = s2 < 8 ? int'(ref_rf[s2]) : 0;
    int x;
    bit w = op >= 1 && op <= 9;
    bit n1 = op >= 2 && op <= 9;
    bit n2 = op >= 3 && op <= 7;
    e = op >= 10 || (w && (rd >= 8 || (n1 && s1 >= 8) || (n2 && s2 >= 8)));
    wr = w && !e;
    case (op)
      1: x = int'(i[7:0]);
      2: x = a;
      3: x = a + b;
      4: x = a - b;
      5: x = a & b;
      6: x = a | b;
      7: x = a ^ b;
      8: x = a * 2;
      9: x = a / 2;
      default: x = 0;
    endcase
    v = x[7:0];
    c = (op == 3 && x > 255) || (op == 4 && a < b) || (op == 8 && a >= 128) || (op == 9 && a % 2 == 1);
  endtask

  task automatic commit(input logic [15:0] i, input bit wr, input logic [7:0] v, input bit c);
    if (wr) begin
      ref_rf[i[10:8]] = v; ref_res = v; ref_z = v == 0; ref_c = c;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_result"}, result, ref_res);
    check({tag, "_zero"}, zero, ref_z);
    check({tag, "_carry"}, carry, ref_c);
    for (int r = 0; r < 8; r++) check({tag, "_rf"}, rf[r], ref_rf[r]);
  endtask

  task automatic run_instr(input logic [15:0] i);
    bit wr, c, e;
    logic [7:0] v;
    int w = 0;
    model(i, wr, v, c, e);
    @(negedge clk);
    instr = i; instr_valid = 1;
    while (!instr_ready && w < 8) begin @(negedge clk); w++; end
    check("ready_wait", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 0; instr = 16'($urandom);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("busy", instr_ready, 0);
      check("done", done, k == 3);
      check("cload", cload, k == 3 && wr);
      check("err", err, k == 3 && e);
      if (k == 1) begin check("asel", asel, i[7:4]); check("bsel", bsel, i[3:0]); end
      if (k == 3 && wr) begin check("csel", csel, i[11:8]); check("cin", cin, v); end
    end
    commit(i, wr, v, c);
    @(negedge clk);
    check("ready_back", instr_ready, 1);
    check("done_low", done, 0);
    check_state("post");
  endtask

  function automatic logic [3:0] rnd_idx();
    return $urandom_range(0, 9) == 0 ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
  endfunction

  logic [15:0] dir [12] = '{16'h113C, 16'h12C4, 16'h3312, 16'h1105, 16'h1207, 16'h4412,
                            16'h2540, 16'h1181, 16'h8610, 16'h9710, 16'hB123, 16'h3812};
  logic [15:0] hs [3] = '{16'h1121, 16'h1234, 16'h3412};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ref_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", instr_ready, 0);
    check("rst_cload", cload, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_sel", {asel, bsel, csel}, 0);
    check("rst_cin", cin, 0);
    check_state("rst");
    rst = 1;
    @(negedge clk);
    check("rst_ready_up", instr_ready, 1);
    // reset in the middle of a WRITE must discard it
    run_instr(16'h1211);
    @(negedge clk);
    instr = 16'h1255; instr_valid = 1;
    @(posedge clk); #1 instr_valid = 0;
    repeat (3) @(negedge clk);
    check("mid_cload_pre", cload, 1);
    rst = 0; #1;
    check("mid_cload", cload, 0);
    check("mid_done", done, 0);
    check("mid_ready", instr_ready, 0);
    check("mid_cin", cin, 0);
    ref_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("mid_ready_up", instr_ready, 1);
    check_state("mid");
    // directed program, including errors and unchecked LDI source fields
    foreach (dir[j]) run_instr(dir[j]);
    run_instr(16'h10FF);
    check("ldi_rsF", rf[0], 8'hFF);
    // valid held high over a stream: one accept per 4 cycles, none dropped or duplicated
    begin
      int n = 0, dn = 0;
      bit wr, c, e;
      logic [7:0] v;
      @(negedge clk);
      instr = hs[0]; instr_valid = 1;
      for (int cyc = 0; cyc < 12; cyc++) begin
        check("hs_ready", instr_ready, cyc % 4 == 0);
        dn += int'(done);
        if (cyc % 4 == 1) begin
          model(hs[n], wr, v, c, e);
          commit(hs[n], wr, v, c);
          n++;
          instr = n < 3 ? hs[n] : 16'h1777;
          instr_valid = n < 3;
        end
        @(negedge clk);
      end
      check("hs_done_count", dn, 3);
      check("hs_ready_end", instr_ready, 1);
      check_state("hs");
    end
    // random instructions, mostly legal with occasional bad indices and ops
    for (int t = 0; t < 60; t++) begin
      logic [3:0] op = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 9));
      logic [15:0] i = {op, rnd_idx(), rnd_idx(), rnd_idx()};
      if (op == 4'd1) i[7:0] = 8'($urandom);
      run_instr(i);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
